mem_wb_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_wb_stage_load_align.sv | 36 +++
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared codes, select values, FSM states and M-register bundle for the MEM/WB stage
package mem_pkg;

    localparam logic [3:0] MEM_LB  = 4'd0;
    localparam logic [3:0] MEM_LH  = 4'd1;
    localparam logic [3:0] MEM_LW  = 4'd2;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd8;
    localparam logic [3:0] MEM_SH  = 4'd9;
    localparam logic [3:0] MEM_SW  = 4'd10;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regwrite;
        logic        rd_en;
        logic        wr_en;
        logic [3:0]  mem_op;
        logic [1:0]  sel;
    } m_bundle_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - selects the addressed byte/half of a load word and sign/zero extends it
module load_align
    import mem_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[7:0];
        case (offset)
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            2'd3:    lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (mem_op)
            MEM_LB:  data = {{24{lane_byte[7]}}, lane_byte};
            MEM_LBU: data = {24'd0, lane_byte};
            MEM_LH:  data = {{16{lane_half[15]}}, lane_half};
            MEM_LHU: data = {16'd0, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage: data-memory handshake, load align, writeback (option MEM_MISALIGN_TRAP_EN)
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EX_valid_i,
    input  logic [DATA_WIDTH-1:0] EX_alu_result_i,
    input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
    input  logic [DATA_WIDTH-1:0] EX_pc_i,
    input  logic [4:0]            EX_rd_add_i,
    input  logic                  EX_regwrite_i,
    input  logic                  EX_RD_en_i,
    input  logic                  EX_WR_en_i,
    input  logic [3:0]            EX_mem_op_i,
    input  logic [1:0]            EX_sel_to_reg_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  mem_stall_o,
    output logic [DATA_WIDTH-1:0] WB_data_o,
    output logic                  WB_regwrite_o,
    output logic [4:0]            WB_rd_add_o,
    output logic                  misalign_o
);

    m_bundle_t  m;
    m_bundle_t  ex_bundle;
    logic       m_done;
    logic       mem_access;
    logic       misaligned;
    logic [31:0] load_data;
    logic [31:0] wb_src;
    mem_state_t state, state_next;

    assign ex_bundle = '{valid: EX_valid_i, alu: EX_alu_result_i, rs2: EX_rs2_data_i,
                         pc: EX_pc_i, rd: EX_rd_add_i, regwrite: EX_regwrite_i,
                         rd_en: EX_RD_en_i, wr_en: EX_WR_en_i, mem_op: EX_mem_op_i,
                         sel: EX_sel_to_reg_i};

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_comb begin
        misaligned = 1'b0;
        if (m.wr_en) begin
            case (m.mem_op)
                MEM_SB:  misaligned = 1'b0;
                MEM_SH:  misaligned = m.alu[0];
                default: misaligned = (m.alu[1:0] != 2'b00);
            endcase
        end else begin
            case (m.mem_op)
                MEM_LB, MEM_LBU: misaligned = 1'b0;
                MEM_LH, MEM_LHU: misaligned = m.alu[0];
                default:         misaligned = (m.alu[1:0] != 2'b00);
            endcase
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign mem_access  = m.valid & (m.rd_en | m.wr_en) & ~misaligned;
    assign dmem_req_o  = mem_access & ~m_done;
    assign dmem_we_o   = m.wr_en;
    assign dmem_addr_o = {m.alu[ADDR_WIDTH-1:2], 2'b00};
    assign mem_stall_o = dmem_req_o & ~dmem_ready_i;

    // Stores replicate data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        dmem_wdata_o = m.rs2;
        dmem_be_o    = 4'b1111;
        if (m.wr_en) begin
            case (m.mem_op)
                MEM_SB: begin
                    dmem_wdata_o = {4{m.rs2[7:0]}};
                    dmem_be_o    = 4'b0001 << m.alu[1:0];
                end
                MEM_SH: begin
                    dmem_wdata_o = {2{m.rs2[15:0]}};
                    dmem_be_o    = m.alu[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem_wdata_o = m.rs2;
                    dmem_be_o    = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= '0;
            m_done <= 1'b0;
        end else begin
            if (dmem_req_o && dmem_ready_i)
                m_done <= 1'b1;
            if (!mem_stall_o) begin
                m      <= ex_bundle;
                m_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dmem_req_o && !dmem_ready_i) state_next = WAIT;
            WAIT:    if (dmem_ready_i || !dmem_req_o) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    load_align u_load_align (
        .mem_op (m.mem_op),
        .offset (m.alu[1:0]),
        .rdata  (dmem_rdata_i),
        .data   (load_data)
    );

    always_comb begin
        case (m.sel)
            SEL_MEM: wb_src = load_data;
            SEL_PC4: wb_src = m.pc + 32'd4;
            default: wb_src = m.alu;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_data_o     <= '0;
            WB_regwrite_o <= 1'b0;
            WB_rd_add_o   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else if (mem_stall_o) begin
            WB_regwrite_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            WB_data_o     <= wb_src;
            WB_regwrite_o <= m.valid & m.regwrite & (m.rd != 5'd0) & ~misaligned;
            WB_rd_add_o   <= m.rd;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q    <= m.valid & misaligned;
`endif
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_valid_i;
    logic [31:0] EX_alu_result_i;
    logic [31:0] EX_rs2_data_i;
    logic [31:0] EX_pc_i;
    logic [4:0]  EX_rd_add_i;
    logic        EX_regwrite_i;
    logic        EX_RD_en_i;
    logic        EX_WR_en_i;
    logic [3:0]  EX_mem_op_i;
    logic [1:0]  EX_sel_to_reg_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_stall_o;
    logic [31:0] WB_data_o;
    logic        WB_regwrite_o;
    logic [4:0]  WB_rd_add_o;
    logic        misalign_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .EX_valid_i      (EX_valid_i),
        .EX_alu_result_i (EX_alu_result_i),
        .EX_rs2_data_i   (EX_rs2_data_i),
        .EX_pc_i         (EX_pc_i),
        .EX_rd_add_i     (EX_rd_add_i),
        .EX_regwrite_i   (EX_regwrite_i),
        .EX_RD_en_i      (EX_RD_en_i),
        .EX_WR_en_i      (EX_WR_en_i),
        .EX_mem_op_i     (EX_mem_op_i),
        .EX_sel_to_reg_i (EX_sel_to_reg_i),
        .dmem_req_o      (dmem_req_o),
        .dmem_we_o       (dmem_we_o),
        .dmem_addr_o     (dmem_addr_o),
        .dmem_wdata_o    (dmem_wdata_o),
        .dmem_be_o       (dmem_be_o),
        .dmem_ready_i    (dmem_ready_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .mem_stall_o     (mem_stall_o),
        .WB_data_o       (WB_data_o),
        .WB_regwrite_o   (WB_regwrite_o),
        .WB_rd_add_o     (WB_rd_add_o),
        .misalign_o      (misalign_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [4:0] rd, input logic regw, input logic rd_en,
                          input logic wr_en, input logic [3:0] op, input logic [1:0] sel);
        EX_valid_i      = 1'b1;
        EX_alu_result_i = alu;
        EX_rs2_data_i   = rs2;
        EX_pc_i         = pc;
        EX_rd_add_i     = rd;
        EX_regwrite_i   = regw;
        EX_RD_en_i      = rd_en;
        EX_WR_en_i      = wr_en;
        EX_mem_op_i     = op;
        EX_sel_to_reg_i = sel;
    endtask

    task automatic ex_bubble;
        EX_valid_i      = 1'b0;
        EX_alu_result_i = 32'd0;
        EX_rs2_data_i   = 32'd0;
        EX_pc_i         = 32'd0;
        EX_rd_add_i     = 5'd0;
        EX_regwrite_i   = 1'b0;
        EX_RD_en_i      = 1'b0;
        EX_WR_en_i      = 1'b0;
        EX_mem_op_i     = 4'd0;
        EX_sel_to_reg_i = 2'b00;
    endtask

    initial begin
        rst_n        = 1'b0;
        dmem_ready_i = 1'b0;
        dmem_rdata_i = 32'd0;
        ex_bubble();
        #12;
        check("rst_req",     {31'd0, dmem_req_o},    32'd0);
        check("rst_stall",   {31'd0, mem_stall_o},   32'd0);
        check("rst_wb_data", WB_data_o,              32'd0);
        check("rst_wb_rw",   {31'd0, WB_regwrite_o}, 32'd0);
        check("rst_wb_rd",   {27'd0, WB_rd_add_o},   32'd0);
        check("rst_misal",   {31'd0, misalign_o},    32'd0);
        rst_n = 1'b1;

        // SW, zero-wait
        ex_set(32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd10, 2'b00);
        tick();
        ex_bubble();
        dmem_ready_i = 1'b1;
        #1;
        check("sw_req",   {31'd0, dmem_req_o},  32'd1);
        check("sw_we",    {31'd0, dmem_we_o},   32'd1);
        check("sw_be",    {28'd0, dmem_be_o},   32'hF);
        check("sw_addr",  dmem_addr_o,          32'h100);
        check("sw_wdata", dmem_wdata_o,         32'hDEADBEEF);
        check("sw_stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        dmem_ready_i = 1'b0;
        check("sw_wb_rw", {31'd0, WB_regwrite_o}, 32'd0);
        check("sw_req_done", {31'd0, dmem_req_o}, 32'd0);

        // LB with three wait cycles
        ex_set(32'h103, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 4'd0, 2'b01);
        tick();
        ex_bubble();
        for (int i = 0; i < 3; i++) begin
            check("lb_stall", {31'd0, mem_stall_o},   32'd1);
            check("lb_addr",  dmem_addr_o,            32'h100);
            check("lb_wb_rw", {31'd0, WB_regwrite_o}, 32'd0);
            tick();
        end
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h80FF_0000;
        #1;
        check("lb_ready_stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        dmem_ready_i = 1'b0;
        check("lb_wb_data", WB_data_o,              32'hFFFFFF80);
        check("lb_wb_rw",   {31'd0, WB_regwrite_o}, 32'd1);
        check("lb_wb_rd",   {27'd0, WB_rd_add_o},   32'd5);

        // LHU, SH, LH, SB back to back with zero-wait memory
        ex_set(32'h202, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 4'd5, 2'b01);
        tick();
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h8001_1234;
        #1;
        check("lhu_stall", {31'd0, mem_stall_o}, 32'd0);
        ex_set(32'h202, 32'h0000ABCD, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd9, 2'b00);
        tick();
        check("lhu_wb_data", WB_data_o,              32'h00008001);
        check("lhu_wb_rw",   {31'd0, WB_regwrite_o}, 32'd1);
        check("lhu_wb_rd",   {27'd0, WB_rd_add_o},   32'd6);
        check("sh_wdata",    dmem_wdata_o,           32'hABCDABCD);
        check("sh_be",       {28'd0, dmem_be_o},     32'hC);
        check("sh_we",       {31'd0, dmem_we_o},     32'd1);
        ex_set(32'h202, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 4'd1, 2'b01);
        tick();
        check("sh_wb_rw", {31'd0, WB_regwrite_o}, 32'd0);
        ex_set(32'h101, 32'h00000012, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd8, 2'b00);
        tick();
        check("lh_wb_data", WB_data_o,          32'hFFFF8001);
        check("lh_wb_rd",   {27'd0, WB_rd_add_o}, 32'd7);
        check("sb_wdata",   dmem_wdata_o,       32'h12121212);
        check("sb_be",      {28'd0, dmem_be_o}, 32'h2);
        check("sb_addr",    dmem_addr_o,        32'h100);
        ex_bubble();
        tick();
        dmem_ready_i = 1'b0;

        // ALU, JAL, write to x0
        ex_set(32'h55, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
        tick();
        ex_set(32'h0, 32'h0, 32'h40, 5'd1, 1'b1, 1'b0, 1'b0, 4'd0, 2'b10);
        tick();
        check("alu_wb_data", WB_data_o,              32'h55);
        check("alu_wb_rw",   {31'd0, WB_regwrite_o}, 32'd1);
        check("alu_wb_rd",   {27'd0, WB_rd_add_o},   32'd3);
        ex_set(32'h77, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 4'd0, 2'b11);
        tick();
        check("jal_wb_data", WB_data_o,            32'h44);
        check("jal_wb_rd",   {27'd0, WB_rd_add_o}, 32'd1);
        ex_bubble();
        tick();
        check("x0_wb_rw",   {31'd0, WB_regwrite_o}, 32'd0);
        check("x0_wb_data", WB_data_o,              32'h77);

        // async reset while a load waits
        ex_set(32'h11, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
        tick();
        ex_set(32'h300, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 4'd2, 2'b01);
        tick();
        ex_bubble();
        check("rstw_stall", {31'd0, mem_stall_o},   32'd1);
        check("rstw_rw",    {31'd0, WB_regwrite_o}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_req_drop",   {31'd0, dmem_req_o},    32'd0);
        check("rstw_stall_drop", {31'd0, mem_stall_o},   32'd0);
        check("rstw_rw_drop",    {31'd0, WB_regwrite_o}, 32'd0);
        #1 rst_n = 1'b1;
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'h12345678;
        tick();
        check("rstw_late_rw",  {31'd0, WB_regwrite_o}, 32'd0);
        check("rstw_late_req", {31'd0, dmem_req_o},    32'd0);
        dmem_ready_i = 1'b0;
        tick();
        check("rstw_late_rw2", {31'd0, WB_regwrite_o}, 32'd0);

        // LW at a misaligned address
        ex_set(32'h101, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 4'd2, 2'b01);
        tick();
        ex_bubble();
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check("mis_req",   {31'd0, dmem_req_o},  32'd0);
        check("mis_stall", {31'd0, mem_stall_o}, 32'd0);
        tick();
        check("mis_pulse", {31'd0, misalign_o},    32'd1);
        check("mis_rw",    {31'd0, WB_regwrite_o}, 32'd0);
        tick();
        check("mis_clear", {31'd0, misalign_o},    32'd0);
`else
        dmem_ready_i = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        #1;
        check("lw_req",  {31'd0, dmem_req_o}, 32'd1);
        check("lw_addr", dmem_addr_o,         32'h100);
        tick();
        dmem_ready_i = 1'b0;
        check("lw_wb_data", WB_data_o,              32'hCAFEF00D);
        check("lw_wb_rw",   {31'd0, WB_regwrite_o}, 32'd1);
        check("lw_misal",   {31'd0, misalign_o},    32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
